// File: rtl/pipeline_ctrl_if.sv
// Hazard/control bundle between the pipeline datapath and pipeline_ctrl.
// master drives hazard sources and sees controls; slave is the controller.
interface pipeline_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  ex_rd;
  logic        ex_is_load;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        pc_sel_target;
  logic        state_wait;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
  logic        mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, pc_sel_target, state_wait, stall_cycles, flush_count,
           mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_is_load,
           ex_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush,
           idex_flush, pc_sel_target, state_wait, stall_cycles, flush_count,
           mem_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// 5-stage pipeline hazard controller: memory-wait freeze, branch flush,
// load-use bubble, with stall/flush counters and a sticky memory timeout.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned PERF_W = 32;
  localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    wait_cnt;
  logic [CNT_W-1:0]    wait_cnt_inc;
  logic [PERF_W-1:0]   stall_cycles;
  logic [PERF_W-1:0]   flush_count;
  logic                mem_timeout;

  logic mw;
  logic br;
  logic lu;
  logic stall_now;
  logic flush_now;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, pc_sel_target;

  // Raw hazard detection
  always_comb begin
    mw = bus.mem_req & ~bus.mem_ready;
    br = bus.ex_branch_taken;
    lu = bus.ex_is_load & (bus.ex_rd != 5'd0) &
         ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
          (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
  end

  // Next state and prioritised pipeline controls (MW > BR > LU)
  always_comb begin
    state_n       = mw ? ST_WAIT : ST_RUN;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    pc_sel_target = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (mw) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (br) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      pc_sel_target = 1'b1;
    end else if (lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_comb begin
    wait_cnt_inc = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
    stall_now    = mw | (~br & lu);
    flush_now    = ~mw & br;
  end

  // Control state, timeout and performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n == ST_RUN) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt_inc;
        if (wait_cnt_inc == TIMEOUT_W) mem_timeout <= 1'b1;
      end
      if (stall_now) stall_cycles <= stall_cycles + PERF_W'(1);
      if (flush_now) flush_count  <= flush_count + PERF_W'(1);
    end
  end

  assign bus.pc_en         = pc_en;
  assign bus.ifid_en       = ifid_en;
  assign bus.idex_en       = idex_en;
  assign bus.exmem_en      = exmem_en;
  assign bus.memwb_en      = memwb_en;
  assign bus.ifid_flush    = ifid_flush;
  assign bus.idex_flush    = idex_flush;
  assign bus.pc_sel_target = pc_sel_target;
  assign bus.state_wait    = (state == ST_WAIT);
  assign bus.stall_cycles  = stall_cycles;
  assign bus.flush_count   = flush_count;
  assign bus.mem_timeout   = mem_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_ctrl_if bus ();

  pipeline_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model state
  bit          m_wait;
  int          m_cnt;
  logic [31:0] m_stall;
  logic [31:0] m_flush;
  bit          m_to;

  function automatic bit mw_m();
    return bus.mem_req && !bus.mem_ready;
  endfunction

  function automatic bit lu_m();
    return bus.ex_is_load && (bus.ex_rd != 0) &&
           ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
            (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
  endfunction

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, pc_sel}
  function automatic logic [7:0] exp_out();
    if (rst)                  return 8'b00000_110;
    if (mw_m())               return 8'b00000_000;
    if (bus.ex_branch_taken)  return 8'b11111_111;
    if (lu_m())               return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  function automatic logic [7:0] got_out();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.pc_sel_target};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_wait <= 1'b0; m_cnt <= 0; m_stall <= '0; m_flush <= '0; m_to <= 1'b0;
    end else if (mw_m()) begin
      m_stall <= m_stall + 1;
      m_wait  <= 1'b1;
      if (m_wait) begin
        m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (m_cnt + 1 >= TO) m_to <= 1'b1;
      end
    end else begin
      m_wait <= 1'b0;
      m_cnt  <= 0;
      if (bus.ex_branch_taken) m_flush <= m_flush + 1;
      else if (lu_m())         m_stall <= m_stall + 1;
    end
  end

  task automatic set_idle();
    bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd2;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = 5'd3; bus.ex_is_load = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; set_idle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_idle();
    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b00000_110) $display("FAIL reset_outs got %b exp %b", got_out(), 8'b00000_110);
    else n_pass++;
    next_cycle();
    rst = 1'b0; set_idle();
    @(negedge clk);
    n_total++;
    if ({bus.stall_cycles, bus.flush_count} !== 64'd0)
      $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.stall_cycles, bus.flush_count);
    else n_pass++;
    n_total++;
    if ({bus.state_wait, bus.mem_timeout} !== 2'b00)
      $display("FAIL reset_state got %b exp 00", {bus.state_wait, bus.mem_timeout});
    else n_pass++;
    n_total++;
    if (got_out() !== 8'b11111_000) $display("FAIL idle_outs got %b exp %b", got_out(), 8'b11111_000);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b00111_010) $display("FAIL load_use_outs got %b exp %b", got_out(), 8'b00111_010);
    else n_pass++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b11111_000) $display("FAIL load_use_release got %b exp %b", got_out(), 8'b11111_000);
    else n_pass++;
    n_total++;
    if (bus.stall_cycles !== 32'd1) $display("FAIL load_use_stall got %0d exp 1", bus.stall_cycles);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_load_x0();
    do_reset();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs2 = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b11111_000) $display("FAIL load_x0_outs got %b exp %b", got_out(), 8'b11111_000);
    else n_pass++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_total++;
    if (bus.stall_cycles !== 32'd0) $display("FAIL load_x0_stall got %0d exp 0", bus.stall_cycles);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_branch_over_load();
    do_reset();
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7; bus.id_uses_rs1 = 1'b1;
    bus.ex_branch_taken = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b11111_111) $display("FAIL branch_outs got %b exp %b", got_out(), 8'b11111_111);
    else n_pass++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_total++;
    if ({bus.flush_count, bus.stall_cycles} !== {32'd1, 32'd0})
      $display("FAIL branch_counters got flush %0d stall %0d exp 1/0", bus.flush_count, bus.stall_cycles);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk);
      n_total++;
      if (got_out() !== 8'b00000_000) $display("FAIL wait_outs[%0d] got %b exp 0", i, got_out());
      else n_pass++;
      n_total++;
      if (bus.state_wait !== (i >= 1)) $display("FAIL wait_state[%0d] got %b exp %b", i, bus.state_wait, i >= 1);
      else n_pass++;
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b11111_000) $display("FAIL wait_release got %b exp %b", got_out(), 8'b11111_000);
    else n_pass++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_total++;
    if ({bus.stall_cycles, bus.state_wait} !== {32'd3, 1'b0})
      $display("FAIL wait_after got stall %0d wait %b exp 3/0", bus.stall_cycles, bus.state_wait);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_branch_freeze();
    do_reset();
    bus.ex_branch_taken = 1'b1; bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    next_cycle();
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b11111_111) $display("FAIL freeze_release got %b exp %b", got_out(), 8'b11111_111);
    else n_pass++;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_total++;
    if ({bus.flush_count, bus.stall_cycles} !== {32'd1, 32'd2})
      $display("FAIL freeze_counters got flush %0d stall %0d exp 1/2", bus.flush_count, bus.stall_cycles);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk);
      n_total++;
      if (bus.mem_timeout !== (i >= 5)) $display("FAIL timeout[%0d] got %b exp %b", i, bus.mem_timeout, i >= 5);
      else n_pass++;
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    next_cycle();
    set_idle();
    @(negedge clk);
    n_total++;
    if (bus.mem_timeout !== 1'b1) $display("FAIL timeout_sticky got %b exp 1", bus.mem_timeout);
    else n_pass++;
    next_cycle();
    do_reset();
    @(negedge clk);
    n_total++;
    if (bus.mem_timeout !== 1'b0) $display("FAIL timeout_clear got %b exp 0", bus.mem_timeout);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (got_out() !== 8'b00000_110) $display("FAIL midwait_rst_outs got %b exp %b", got_out(), 8'b00000_110);
    else n_pass++;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if ({bus.state_wait, bus.stall_cycles, bus.flush_count} !== 65'd0)
      $display("FAIL midwait_after got wait %b stall %0d flush %0d exp 0", bus.state_wait, bus.stall_cycles, bus.flush_count);
    else n_pass++;
    next_cycle();
    @(negedge clk);
    n_total++;
    if (bus.state_wait !== 1'b1) $display("FAIL midwait_reenter got %b exp 1", bus.state_wait);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst                 = ($urandom_range(0, 99) < 2);
      bus.mem_req         = ($urandom_range(0, 99) < 35);
      bus.mem_ready       = ($urandom_range(0, 99) < 40);
      bus.ex_branch_taken = ($urandom_range(0, 99) < 15);
      bus.ex_is_load      = ($urandom_range(0, 99) < 45);
      bus.ex_rd           = 5'($urandom_range(0, 3));
      bus.id_rs1          = 5'($urandom_range(0, 3));
      bus.id_rs2          = 5'($urandom_range(0, 3));
      bus.id_uses_rs1     = 1'($urandom_range(0, 1));
      bus.id_uses_rs2     = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_total++;
      if (got_out() !== exp_out()) $display("FAIL rand_outs[%0d] got %b exp %b", i, got_out(), exp_out());
      else n_pass++;
      n_total++;
      if ({bus.stall_cycles, bus.flush_count} !== {m_stall, m_flush})
        $display("FAIL rand_counters[%0d] got %0d/%0d exp %0d/%0d", i, bus.stall_cycles, bus.flush_count, m_stall, m_flush);
      else n_pass++;
      n_total++;
      if ({bus.state_wait, bus.mem_timeout} !== {m_wait, m_to})
        $display("FAIL rand_state[%0d] got %b exp %b", i, {bus.state_wait, bus.mem_timeout}, {m_wait, m_to});
      else n_pass++;
      next_cycle();
    end
    rst = 1'b0; set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_load_x0();
    test_branch_over_load();
    test_mem_wait();
    test_branch_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: memory-wait cycles before timeout error (1..65535).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
REQ-006 ex_rd  in  5  destination index of the instruction in EX.
REQ-007 ex_is_load  in  1  EX instruction is a load.
REQ-008 ex_branch_taken  in  1  EX resolved a taken branch or jump.
REQ-009 mem_req, mem_ready  in  1 each  data-memory request from MEM stage / memory completion.
REQ-010 pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  enables for the PC and the four pipeline registers.
REQ-011 ifid_flush, idex_flush  out  1 each  load a bubble (NOP) into IF/ID / ID/EX this cycle.
REQ-012 pc_sel_target  out  1  PC loads branch target instead of PC+4.
REQ-013 state_wait  out  1  FSM is in WAIT.
REQ-014 stall_cycles, flush_count  out  32 each  performance counters.
REQ-015 mem_timeout  out  1  sticky memory-timeout error.

Function
REQ-016 FSM has exactly two states, RUN and WAIT; the registered state and the wait counter are the only control state.
REQ-017 Hazard conditions (combinational): MW = mem_req & ~mem_ready; BR = ex_branch_taken; LU = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
REQ-018 Priority when several hold together: MW > BR > LU.
REQ-019 MW (either state): all five enables 0, both flushes 0, pc_sel_target 0; pipeline frozen, BR/LU ignored this cycle.
REQ-020 BR without MW: all enables 1, ifid_flush=1, idex_flush=1, pc_sel_target=1.
REQ-021 LU without MW/BR: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1; exactly one bubble per load-use pair, since the load leaves EX next cycle.
REQ-022 No hazard: all enables 1, flushes 0, pc_sel_target 0.
REQ-023 A flush overrides data: flushed register loads NOP even though its enable is 1.
REQ-024 Transitions: RUN->WAIT on MW; WAIT stays on MW; WAIT->RUN when mem_ready=1 (outputs that cycle per REQ-020..022, i.e. same-cycle release).
REQ-025 Wait counter (16 bit): cleared on entry to RUN; increments each WAIT cycle with MW; saturates at 65535.
REQ-026 mem_timeout sets when wait counter reaches TIMEOUT_CYCLES; remains 1 until rst; does not alter enables.
REQ-027 stall_cycles +1 every cycle any of pc_en/ifid_en is 0 (MW or LU); flush_count +1 every cycle BR is acted on; both wrap modulo 2^32.
REQ-028 BR held during a freeze counts once, in the release cycle only.
REQ-029 Outputs in REQ-019..022 are combinational from inputs and state; counters, state, mem_timeout registered.

Reset
REQ-030 On clk edge with rst=1: state=RUN, wait counter=0, stall_cycles=0, flush_count=0, mem_timeout=0.
REQ-031 While rst=1: all enables 0, ifid_flush=1, idex_flush=1, pc_sel_target=0, regardless of other inputs.
REQ-032 rst during WAIT aborts the wait; first cycle after rst deassert evaluates from RUN.

Verification
REQ-033 ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 one cycle -> pc_en=0, ifid_en=0, idex_flush=1; next cycle (load gone) all enables 1; stall_cycles=1.
REQ-034 Same as REQ-033 with ex_rd=0 -> no stall, stall_cycles=0.
REQ-035 ex_branch_taken=1 together with LU -> ifid_flush=idex_flush=1, pc_sel_target=1, pc_en=1; flush_count=1, stall_cycles=0.
REQ-036 mem_req=1, mem_ready=0 for 3 cycles then 1 -> all enables 0 for 3 cycles, state_wait=1 from 2nd cycle, release cycle all enables 1; stall_cycles=3.
REQ-037 TIMEOUT_CYCLES=4, mem_ready held 0 for 10 cycles -> mem_timeout=1 after 4th WAIT cycle, stays 1 after release, clears only on rst.
REQ-038 rst pulsed mid-WAIT -> during rst flushes 1, enables 0; after rst counters 0, state_wait=0.
